matrix_stream_packer: RTL and testbench
=======================================

// Module: matrix_stream_packer
// PURPOSE
//   Upstream feeder of the transpose stage. Accepts a row-major element stream, BEAT_ELEMS elements per beat, over a valid/ready handshake.
//   Assembles one full flattened matrix in a register and presents it on the wide bus that the transpose stage consumes.
//   Holds the matrix with matrix_valid until the consumer accepts it with matrix_valid && matrix_ready.
// PARAMETERS
//   DATA_WIDTH     8    bits per element
//   INPUT_SHAPE_1  128  rows
//   INPUT_SHAPE_2  768  columns
//   INPUT_SHAPE_3  1    depth
//   BEAT_ELEMS     4    elements per input beat; must divide TOTAL = S1*S2*S3
//   Derived: BEATS = TOTAL/BEAT_ELEMS; CNT_W = max(1, $clog2(BEATS))
// PORTS
//   clk_p         in   1                     clock; all logic on the rising edge
//   rst_n         in   1                     synchronous, active-low reset
//   clear         in   1                     synchronous abort of the partial fill
//   in_valid      in   1                     beat valid
//   in_ready      out  1                     beat accepted when in_valid && in_ready
//   in_data       in   BEAT_ELEMS*DATA_WIDTH lane l at [(l+1)*DW-1 : l*DW]
//   matrix_valid  out  1                     full matrix available
//   matrix_ready  in   1                     consumer accepts the matrix
//   matrix        out  TOTAL*DATA_WIDTH      element k = i*S2+j at [(k+1)*DW-1 : k*DW], signed
// BEHAVIOUR
//   Reset values: state=FILL, beat_cnt=0, in_ready=1, matrix_valid=0, matrix=0, frame_err=0.
//   FSM FILL:
//     - in_ready=1, matrix_valid=0.
//     - On an accepted beat, lane l is written to element beat_cnt*BEAT_ELEMS+l.
//     - If beat_cnt==BEATS-1: beat_cnt->0 and state->FULL. Otherwise beat_cnt++.
//   FSM FULL:
//     - in_ready=0, matrix_valid=1.
//     - matrix is stable until matrix_ready=1. Then state->FILL on the next cycle.
//   Latency: matrix_valid rises on the cycle after the last beat is accepted.
//   Throughput: at most one matrix per BEATS+1 cycles. FULL never accepts beats.
//   The matrix register is not cleared between frames. Every element is overwritten before the next matrix_valid.
//   clear=1 (outside reset): beat_cnt->0, state->FILL, matrix_valid->0, matrix contents unchanged.
//     - clear takes priority over a simultaneous beat (beat discarded) and over a simultaneous matrix handshake.
//   rst_n=0 overrides clear and all handshakes. Reset mid-fill discards the partial matrix.
//   BEATS=1: every accepted beat goes straight to FULL.
//   in_data is ignored when in_valid=0 or in_ready=0.
// CONFIGURATION
//   MATRIX_PACK_LAST_CHECK_EN defined:
//     - Adds input in_last (1, qualifies the beat) and output frame_err (1, sticky).
//     - in_last on a beat with beat_cnt<BEATS-1: frame_err->1, beat_cnt->0, partial data dropped, stays FILL.
//     - Final beat without in_last: frame_err->1, matrix still completes to FULL.
//     - frame_err is cleared only by rst_n=0 or clear=1.
//   Not defined: in_last and frame_err ports absent, no framing check, logic identical otherwise.
// TESTING  (DW=8, S1=2, S2=3, S3=1, BEAT_ELEMS=2 -> 3 beats, 48-bit matrix)
//   1. rst_n=0 for 2 cycles, then 1
//      -> in_ready=1, matrix_valid=0, matrix=48'h0.
//   2. Beats 16'h0201, 16'h0403, 16'h0605 on consecutive cycles, matrix_ready=1
//      -> matrix_valid=1 for exactly one cycle, starting the cycle after beat 3;
//      -> matrix=48'h060504030201; in_ready=1 again the cycle after.
//   3. As test 2 with matrix_ready=0 for 5 cycles
//      -> matrix_valid and matrix held, in_ready=0;
//      -> matrix_ready=1 gives in_ready=1 the next cycle.
//   4. in_valid toggled 1,0,0,1,0,1 carrying the same beats
//      -> only valid beats counted; same matrix produced after the 3rd valid beat.
//   5. Two beats, then clear=1 with in_valid=1 on the same cycle, then beats 16'h1211, 16'h1413, 16'h1615
//      -> matrix=48'h161514131211; clear-cycle beat dropped.
//   6. LAST_CHECK_EN: in_last on beat 2
//      -> frame_err=1, no matrix_valid;
//      -> 3 correctly framed beats then give a valid matrix, frame_err stays 1 until clear.

Source files
------------

// File: rtl/matrix_stream_packer.sv
// matrix_stream_packer: gathers a row-major element stream (BEAT_ELEMS
// elements per beat) into one flattened matrix register and holds it on a
// wide bus until the consumer takes it.
// Optional build macro MATRIX_PACK_LAST_CHECK_EN adds in_last framing and a
// sticky frame_err flag.
module matrix_stream_packer #(
  parameter int DATA_WIDTH    = 8,
  parameter int INPUT_SHAPE_1 = 128,
  parameter int INPUT_SHAPE_2 = 768,
  parameter int INPUT_SHAPE_3 = 1,
  parameter int BEAT_ELEMS    = 4
) (
  input  logic                                                          clk_p,
  input  logic                                                          rst_n,
  input  logic                                                          clear,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  input  logic [BEAT_ELEMS*DATA_WIDTH-1:0]                              in_data,
`ifdef MATRIX_PACK_LAST_CHECK_EN
  input  logic                                                          in_last,
  output logic                                                          frame_err,
`endif
  output logic                                                          matrix_valid,
  input  logic                                                          matrix_ready,
  output logic [INPUT_SHAPE_1*INPUT_SHAPE_2*INPUT_SHAPE_3*DATA_WIDTH-1:0] matrix
);

  localparam int TOTAL = INPUT_SHAPE_1 * INPUT_SHAPE_2 * INPUT_SHAPE_3;
  localparam int BEATS = TOTAL / BEAT_ELEMS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] beat_cnt, cnt_next;
  logic             beat_fire;
  logic             early_last;
  logic             wr_en;
`ifdef MATRIX_PACK_LAST_CHECK_EN
  logic             err_next;
`endif

  assign beat_fire = in_valid && in_ready;

`ifdef MATRIX_PACK_LAST_CHECK_EN
  assign early_last = in_last && (beat_cnt != LAST_CNT);
`else
  assign early_last = 1'b0;
`endif

  // A beat is stored unless clear discards it or it terminates a short frame.
  assign wr_en = beat_fire && !clear && !early_last;

  // State, beat counter and (optional) error flag registers.
  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state    <= FILL;
      beat_cnt <= '0;
`ifdef MATRIX_PACK_LAST_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      beat_cnt <= cnt_next;
`ifdef MATRIX_PACK_LAST_CHECK_EN
      frame_err <= err_next;
`endif
    end
  end

  // Next-state, counter and handshake outputs; clear overrides beats and
  // the matrix handshake.
  always_comb begin
    state_next   = state;
    cnt_next     = beat_cnt;
    in_ready     = 1'b0;
    matrix_valid = 1'b0;
`ifdef MATRIX_PACK_LAST_CHECK_EN
    err_next     = frame_err;
`endif
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (beat_fire) begin
          if (early_last) begin
            cnt_next = '0;
`ifdef MATRIX_PACK_LAST_CHECK_EN
            err_next = 1'b1;
`endif
          end else if (beat_cnt == LAST_CNT) begin
            cnt_next   = '0;
            state_next = FULL;
`ifdef MATRIX_PACK_LAST_CHECK_EN
            if (!in_last) err_next = 1'b1;
`endif
          end else begin
            cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        matrix_valid = 1'b1;
        if (matrix_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    if (clear) begin
      state_next = FILL;
      cnt_next   = '0;
`ifdef MATRIX_PACK_LAST_CHECK_EN
      err_next   = 1'b0;
`endif
    end
  end

  // Matrix storage: each accepted beat fills BEAT_ELEMS consecutive elements.
  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      matrix <= '0;
    end else if (wr_en) begin
      for (int unsigned l = 0; l < BEAT_ELEMS; l++) begin
        matrix[(32'(beat_cnt) * BEAT_ELEMS + l) * DATA_WIDTH +: DATA_WIDTH]
          <= in_data[l * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_packer.sv
// Scoreboard bench for matrix_stream_packer on a 2x3x1 matrix of bytes,
// two elements per beat (three beats per matrix, 48-bit matrix bus).
module tb_matrix_stream_packer;

  localparam int DW = 8;
  localparam int BE = 2;
  localparam int MW = 2 * 3 * 1 * DW;

  logic          clk_p = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [BE*DW-1:0] in_data;
  logic          in_last;
  logic          frame_err;
  logic          matrix_valid;
  logic          matrix_ready;
  logic [MW-1:0] matrix;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_q[$];

  matrix_stream_packer #(
    .DATA_WIDTH    (DW),
    .INPUT_SHAPE_1 (2),
    .INPUT_SHAPE_2 (3),
    .INPUT_SHAPE_3 (1),
    .BEAT_ELEMS    (BE)
  ) dut (
    .clk_p        (clk_p),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
`ifdef MATRIX_PACK_LAST_CHECK_EN
    .in_last      (in_last),
    .frame_err    (frame_err),
`endif
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready),
    .matrix       (matrix)
  );

`ifndef MATRIX_PACK_LAST_CHECK_EN
  assign frame_err = 1'b0;
`endif

  always #5 clk_p = ~clk_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // One cycle of input: the beat is presented for exactly one clock edge.
  task automatic beat(input logic [BE*DW-1:0] d, input logic v, input logic last);
    in_valid = v;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic frame(input logic [BE*DW-1:0] b0, b1, b2);
    exp_q.push_back({b2, b1, b0});
    beat(b0, 1'b1, 1'b0);
    beat(b1, 1'b1, 1'b0);
    beat(b2, 1'b1, 1'b1);
  endtask

  // Scoreboard: every completed matrix handshake pops one expected matrix.
  always @(negedge clk_p) begin
    if (rst_n && !clear && matrix_valid && matrix_ready) begin
      if (exp_q.size() == 0) check("unexpected_matrix", 64'(matrix), 64'hDEAD);
      else check("sb_matrix", 64'(matrix), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; matrix_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    // 1: reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(matrix_valid), 64'd0);
    check("rst_matrix", 64'(matrix), 64'h0);
    check("rst_ferr", 64'(frame_err), 64'd0);

    // 2: back-to-back beats, consumer ready
    matrix_ready = 1'b1;
    frame(16'h0201, 16'h0403, 16'h0605);
    check("t2_valid", 64'(matrix_valid), 64'd1);
    check("t2_ready_low", 64'(in_ready), 64'd0);
    check("t2_matrix", 64'(matrix), 64'h060504030201);
    tick();
    check("t2_valid_1cyc", 64'(matrix_valid), 64'd0);
    check("t2_ready_back", 64'(in_ready), 64'd1);

    // 3: consumer stalls five cycles
    matrix_ready = 1'b0;
    frame(16'hA1B2, 16'hC3D4, 16'hE5F6);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(matrix_valid), 64'd1);
      check("t3_hold_ready", 64'(in_ready), 64'd0);
      check("t3_hold_matrix", 64'(matrix), 64'hE5F6C3D4A1B2);
      tick();
    end
    matrix_ready = 1'b1;
    tick();
    check("t3_release_ready", 64'(in_ready), 64'd1);
    check("t3_release_valid", 64'(matrix_valid), 64'd0);

    // 4: gaps in in_valid; idle cycles carry junk data
    exp_q.push_back(48'h060504030201);
    beat(16'h0201, 1'b1, 1'b0);
    beat(16'hFFFF, 1'b0, 1'b0);
    beat(16'hEEEE, 1'b0, 1'b1);
    beat(16'h0403, 1'b1, 1'b0);
    check("t4_not_yet", 64'(matrix_valid), 64'd0);
    beat(16'hDDDD, 1'b0, 1'b0);
    beat(16'h0605, 1'b1, 1'b1);
    check("t4_valid", 64'(matrix_valid), 64'd1);
    tick();

    // 5: clear with a simultaneous beat drops it and restarts the fill
    beat(16'h7777, 1'b1, 1'b0);
    beat(16'h8888, 1'b1, 1'b0);
    clear = 1'b1;
    beat(16'h9999, 1'b1, 1'b1);
    clear = 1'b0;
    check("t5_clear_valid", 64'(matrix_valid), 64'd0);
    check("t5_clear_ready", 64'(in_ready), 64'd1);
    frame(16'h1211, 16'h1413, 16'h1615);
    check("t5_valid", 64'(matrix_valid), 64'd1);
    check("t5_matrix", 64'(matrix), 64'h161514131211);
    tick();

    // clear while FULL beats a simultaneous handshake; contents kept
    matrix_ready = 1'b0;
    beat(16'h2221, 1'b1, 1'b0);
    beat(16'h2423, 1'b1, 1'b0);
    beat(16'h2625, 1'b1, 1'b1);
    check("full_valid", 64'(matrix_valid), 64'd1);
    clear = 1'b1;
    matrix_ready = 1'b1;
    @(posedge clk_p); #1;
    clear = 1'b0;
    matrix_ready = 1'b0;
    check("full_clear_valid", 64'(matrix_valid), 64'd0);
    check("full_clear_matrix", 64'(matrix), 64'h262524232221);
    matrix_ready = 1'b1;

    // reset mid-fill discards the partial matrix
    beat(16'h3231, 1'b1, 1'b0);
    rst_n = 1'b0;
    beat(16'h3433, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("midrst_matrix", 64'(matrix), 64'h0);
    frame(16'h4241, 16'h4443, 16'h4645);
    check("midrst_valid", 64'(matrix_valid), 64'd1);
    tick();

`ifdef MATRIX_PACK_LAST_CHECK_EN
    // 6: early in_last aborts the frame and sets the sticky error
    beat(16'h5251, 1'b1, 1'b0);
    beat(16'h5453, 1'b1, 1'b1);
    check("t6_ferr", 64'(frame_err), 64'd1);
    check("t6_no_valid", 64'(matrix_valid), 64'd0);
    frame(16'h6261, 16'h6463, 16'h6665);
    check("t6_valid", 64'(matrix_valid), 64'd1);
    check("t6_ferr_sticky", 64'(frame_err), 64'd1);
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    check("t6_ferr_cleared", 64'(frame_err), 64'd0);
    // final beat without in_last still completes but flags the error
    exp_q.push_back(48'h767574737271);
    beat(16'h7271, 1'b1, 1'b0);
    beat(16'h7473, 1'b1, 1'b0);
    beat(16'h7675, 1'b1, 1'b0);
    check("t6_nolast_valid", 64'(matrix_valid), 64'd1);
    check("t6_nolast_ferr", 64'(frame_err), 64'd1);
    tick();
`endif

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
